// File: rtl/day10_pkg.sv
// Shared widths, ASCII byte constants and parser state encoding for the
// day-10 line parser.
package day10_pkg;

  localparam int DEF_MAX_NUM_LIGHTS  = 6;
  localparam int DEF_MAX_NUM_BUTTONS = 6;
  localparam int DEF_MAX_NUM_LIGHTS_W =
    (DEF_MAX_NUM_LIGHTS <= 1) ? 1 : $clog2(DEF_MAX_NUM_LIGHTS + 1);
  localparam int DEF_MAX_NUM_BUTTONS_W =
    (DEF_MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(DEF_MAX_NUM_BUTTONS + 1);

  localparam logic [7:0] CH_LBRACK = 8'h5B; // '['
  localparam logic [7:0] CH_RBRACK = 8'h5D; // ']'
  localparam logic [7:0] CH_LPAREN = 8'h28; // '('
  localparam logic [7:0] CH_RPAREN = 8'h29; // ')'
  localparam logic [7:0] CH_LBRACE = 8'h7B; // '{'
  localparam logic [7:0] CH_COMMA  = 8'h2C; // ','
  localparam logic [7:0] CH_DOT    = 8'h2E; // '.'
  localparam logic [7:0] CH_HASH   = 8'h23; // '#'
  localparam logic [7:0] CH_NL     = 8'h0A; // '\n'
  localparam logic [7:0] CH_0      = 8'h30; // '0'
  localparam logic [7:0] CH_9      = 8'h39; // '9'

  typedef enum logic [2:0] {
    SEEK,
    LIGHTS,
    GAP,
    BUTTON,
    SKIP,
    DRAIN,
    EMIT
  } state_e;

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= CH_0) && (ch <= CH_9);
  endfunction

endpackage

// File: rtl/day10_index_accum.sv
// Decimal digit accumulator for button light indices. Saturates at the
// all-ones value of its width so oversized indices are still caught by the
// range check in the parser rather than wrapping into a legal value.
module day10_index_accum #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [3:0]       digit,
  output logic [IDX_W-1:0] idx
);

  localparam int WIDE_W = IDX_W + 4;
  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

  logic [WIDE_W-1:0] wide;
  logic [IDX_W-1:0]  idx_next;

  // idx*10 + digit in a width that cannot overflow, then clamp
  always_comb begin
    wide     = ({4'd0, idx} * WIDE_W'(10)) + WIDE_W'(digit);
    idx_next = wide[IDX_W-1:0];
    if (wide > WIDE_W'(IDX_MAX)) begin
      idx_next = IDX_MAX;
    end
  end

  // Accumulator register; clear wins over a new digit
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx_next;
    end
  end

endmodule

// File: rtl/day10_line_parser.sv
// AXI-Stream byte parser turning "[.##.] (3) (1,3) ... {..}" lines into a
// light target mask plus per-button toggle masks, handed to the consumer
// with a start/accepted handshake. The joltage group is skipped.
module day10_line_parser
  import day10_pkg::*;
#(
  parameter int MAX_NUM_LIGHTS    = DEF_MAX_NUM_LIGHTS,
  parameter int MAX_NUM_BUTTONS   = DEF_MAX_NUM_BUTTONS,
  parameter int MAX_NUM_LIGHTS_W  =
    (MAX_NUM_LIGHTS <= 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
  parameter int MAX_NUM_BUTTONS_W =
    (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             s_axis_tvalid,
  output logic                                             s_axis_tready,
  input  logic [7:0]                                       s_axis_tdata,
  input  logic                                             s_axis_tlast,
  output logic                                             start,
  input  logic                                             ready,
  input  logic                                             accepted,
  output logic [MAX_NUM_LIGHTS_W-1:0]                      num_lights,
  output logic [MAX_NUM_LIGHTS-1:0]                        target_lights,
  output logic [MAX_NUM_BUTTONS_W-1:0]                     num_buttons,
  output logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]   buttons,
  output logic                                             parse_err,
  output logic [15:0]                                      lines_out
);

  state_e state_q, state_d;

  logic [MAX_NUM_LIGHTS_W-1:0]                    count_q;
  logic [MAX_NUM_LIGHTS-1:0]                      target_q;
  logic [MAX_NUM_BUTTONS_W-1:0]                   nbtn_q;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] btn_q;
  logic                                           err_q;
  logic [15:0]                                    lines_q;

  logic [MAX_NUM_LIGHTS_W-1:0] idx;
  logic [7:0] ch;
  logic beat;
  logic bad;
  logic err_set;
  logic act_clear, act_light, act_hash, act_open, act_commit, act_close;
  logic acc_clr, acc_en;

  // The consumer's idle flag does not gate emission; kept only for visibility.
  logic unused_ready;
  assign unused_ready = ready;

  assign ch            = s_axis_tdata;
  assign s_axis_tready = !rst && (state_q != EMIT);
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign start         = (state_q == EMIT);

  assign num_lights    = count_q;
  assign target_lights = target_q;
  assign num_buttons   = nbtn_q;
  assign buttons       = btn_q;
  assign parse_err     = err_q;
  assign lines_out     = lines_q;

  day10_index_accum #(
    .IDX_W (MAX_NUM_LIGHTS_W)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .digit (ch[3:0]),
    .idx   (idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEEK;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-byte decode: next state, record actions and error detection.
  // A tlast beat is treated as if a '\n' followed it within the line.
  always_comb begin
    state_d    = state_q;
    bad        = 1'b0;
    err_set    = 1'b0;
    act_clear  = 1'b0;
    act_light  = 1'b0;
    act_hash   = 1'b0;
    act_open   = 1'b0;
    act_commit = 1'b0;
    act_close  = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;

    if (beat) begin
      unique case (state_q)
        SEEK: begin
          if (ch == CH_LBRACK) begin
            act_clear = 1'b1;
            state_d   = LIGHTS;
          end
        end
        LIGHTS: begin
          if (ch == CH_DOT || ch == CH_HASH) begin
            if (count_q == MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS)) begin
              bad = 1'b1;
            end else begin
              act_light = 1'b1;
              act_hash  = (ch == CH_HASH);
            end
          end else if (ch == CH_RBRACK) begin
            state_d = GAP;
          end else begin
            bad = 1'b1;
          end
        end
        GAP: begin
          if (ch == CH_LPAREN) begin
            if (nbtn_q == MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS)) begin
              bad = 1'b1;
            end else begin
              act_open = 1'b1;
              acc_clr  = 1'b1;
              state_d  = BUTTON;
            end
          end else if (ch == CH_LBRACE) begin
            state_d = SKIP;
          end else if (ch == CH_NL) begin
            state_d = EMIT;
          end
        end
        BUTTON: begin
          if (is_digit(ch)) begin
            acc_en = 1'b1;
          end else if (ch == CH_COMMA || ch == CH_RPAREN) begin
            if (idx >= count_q) begin
              bad = 1'b1;
            end else begin
              act_commit = 1'b1;
              acc_clr    = 1'b1;
              if (ch == CH_RPAREN) begin
                act_close = 1'b1;
                state_d   = GAP;
              end
            end
          end else begin
            bad = 1'b1;
          end
        end
        SKIP: begin
          if (ch == CH_NL) begin
            state_d = EMIT;
          end
        end
        DRAIN: begin
          if (ch == CH_NL || s_axis_tlast) begin
            state_d = SEEK;
          end
        end
        default: ;
      endcase

      if (bad) begin
        // A malformed '\n' or tlast byte already ends the line
        err_set = 1'b1;
        state_d = (ch == CH_NL || s_axis_tlast) ? SEEK : DRAIN;
      end else if (s_axis_tlast &&
                   (state_q == LIGHTS || state_q == GAP ||
                    state_q == BUTTON || state_q == SKIP)) begin
        unique case (state_d)
          GAP, SKIP:      state_d = EMIT;
          LIGHTS, BUTTON: begin
            err_set = 1'b1;
            state_d = SEEK;
          end
          default: ;
        endcase
      end
    end else if (state_q == EMIT && accepted) begin
      state_d = SEEK;
    end
  end

  // Working record: cleared on '[', built up byte by byte, held in EMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      target_q <= '0;
      nbtn_q   <= '0;
      btn_q    <= '0;
    end else begin
      if (act_clear) begin
        count_q  <= '0;
        target_q <= '0;
        nbtn_q   <= '0;
        btn_q    <= '0;
      end
      if (act_light) begin
        for (int l = 0; l < MAX_NUM_LIGHTS; l++) begin
          if (act_hash && count_q == MAX_NUM_LIGHTS_W'(l)) begin
            target_q[l] <= 1'b1;
          end
        end
        count_q <= count_q + MAX_NUM_LIGHTS_W'(1);
      end
      if (act_open) begin
        for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
          if (nbtn_q == MAX_NUM_BUTTONS_W'(b)) begin
            btn_q[b] <= '0;
          end
        end
      end
      if (act_commit) begin
        for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
          for (int l = 0; l < MAX_NUM_LIGHTS; l++) begin
            if (nbtn_q == MAX_NUM_BUTTONS_W'(b) && idx == MAX_NUM_LIGHTS_W'(l)) begin
              btn_q[b][l] <= 1'b1;
            end
          end
        end
      end
      if (act_close) begin
        nbtn_q <= nbtn_q + MAX_NUM_BUTTONS_W'(1);
      end
    end
  end

  // Sticky error flag and accepted-record counter
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      lines_q <= '0;
    end else begin
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (start && accepted) begin
        lines_q <= lines_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_day10_line_parser.sv
// Directed bench for day10_line_parser: a table of whole lines with their
// expected records, plus hand sequences for backpressure and mid-line reset.
module tb_day10_line_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [7:0]      s_axis_tdata;
  logic            s_axis_tlast;
  logic            start;
  logic            ready;
  logic            accepted;
  logic [2:0]      num_lights;
  logic [5:0]      target_lights;
  logic [2:0]      num_buttons;
  logic [5:0][5:0] buttons;
  logic            parse_err;
  logic [15:0]     lines_out;

  day10_line_parser dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .start         (start),
    .ready         (ready),
    .accepted      (accepted),
    .num_lights    (num_lights),
    .target_lights (target_lights),
    .num_buttons   (num_buttons),
    .buttons       (buttons),
    .parse_err     (parse_err),
    .lines_out     (lines_out)
  );

  typedef struct {
    string           line;
    bit              use_tlast;
    bit              rec;
    bit              err;
    logic [2:0]      nl;
    logic [5:0]      tgt;
    logic [2:0]      nb;
    logic [5:0][5:0] btn;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_lines = 0;

  function automatic logic [35:0] mkb(input logic [5:0] b0, b1, b2, b3, b4, b5);
    return {b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!s_axis_tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("tready_timeout", {63'd0, s_axis_tready}, 64'd1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_line(input string s, input bit use_tlast);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], use_tlast && (i == s.len() - 1));
    end
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (start) seen = 1'b1;
    end
  endtask

  task automatic accept_pulse(input string name);
    @(negedge clk);
    accepted = 1'b1;
    @(posedge clk);
    #1;
    accepted = 1'b0;
    exp_lines++;
    @(negedge clk);
    chk({name, "_start_drop"}, {63'd0, start}, 64'd0);
    chk({name, "_lines_out"}, {48'd0, lines_out}, exp_lines);
  endtask

  task automatic check_vec(input string name, input vec_t v);
    bit seen;
    send_line(v.line, v.use_tlast);
    wait_start(seen);
    chk({name, "_start"}, {63'd0, seen}, {63'd0, v.rec});
    chk({name, "_parse_err"}, {63'd0, parse_err}, {63'd0, v.err});
    if (v.rec && seen) begin
      chk({name, "_num_lights"}, {61'd0, num_lights}, {61'd0, v.nl});
      chk({name, "_target"}, {58'd0, target_lights}, {58'd0, v.tgt});
      chk({name, "_num_buttons"}, {61'd0, num_buttons}, {61'd0, v.nb});
      chk({name, "_buttons"}, {28'd0, buttons}, {28'd0, v.btn});
      accept_pulse(name);
    end
  endtask

  vec_t vecs[10];

  initial begin
    bit seen;
    logic [35:0] held_btn;

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'd0;
    s_axis_tlast  = 1'b0;
    ready    = 1'b1;
    accepted = 1'b0;

    vecs[0] = '{"[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 0, 1, 0,
                3'd4, 6'h06, 3'd6, mkb(6'h08, 6'h0A, 6'h04, 6'h0C, 6'h05, 6'h03)};
    vecs[1] = '{"[...#.] (0,2,3,4) (2,3) (0,4) (0,1,2) (1,2,3,4) {7,5,12,7,2}", 1, 1, 0,
                3'd5, 6'h08, 3'd5, mkb(6'h1D, 6'h0C, 6'h11, 6'h07, 6'h1E, 6'h00)};
    vecs[2] = '{"[#..#] {1}\n", 0, 1, 0,
                3'd4, 6'h09, 3'd0, mkb(0, 0, 0, 0, 0, 0)};
    vecs[3] = '{"[##]x (0,1)\n", 0, 1, 0,
                3'd2, 6'h03, 3'd1, mkb(6'h03, 0, 0, 0, 0, 0)};
    vecs[4] = '{"[######] (5) (0)\n", 0, 1, 0,
                3'd6, 6'h3F, 3'd2, mkb(6'h20, 6'h01, 0, 0, 0, 0)};
    vecs[5] = '{"[#######] (0)\n", 0, 0, 1, 3'd0, 6'h00, 3'd0, mkb(0, 0, 0, 0, 0, 0)};
    vecs[6] = '{"[#.] (1)\n", 0, 1, 1,
                3'd2, 6'h01, 3'd1, mkb(6'h02, 0, 0, 0, 0, 0)};
    vecs[7] = '{"[.#] (5)\n", 0, 0, 1, 3'd0, 6'h00, 3'd0, mkb(0, 0, 0, 0, 0, 0)};
    vecs[8] = '{"\n\n", 0, 0, 1, 3'd0, 6'h00, 3'd0, mkb(0, 0, 0, 0, 0, 0)};
    vecs[9] = '{"[#] (0) (0) (0) (0) (0) (0) (0)\n", 0, 0, 1,
                3'd0, 6'h00, 3'd0, mkb(0, 0, 0, 0, 0, 0)};

    // Reset state
    repeat (3) @(negedge clk);
    chk("tready_in_reset", {63'd0, s_axis_tready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tready", {63'd0, s_axis_tready}, 64'd1);
    chk("reset_start", {63'd0, start}, 64'd0);
    chk("reset_err", {63'd0, parse_err}, 64'd0);
    chk("reset_lines", {48'd0, lines_out}, 64'd0);
    chk("reset_fields", {25'd0, num_lights, target_lights, num_buttons, buttons}, 64'd0);

    // Table of whole lines
    for (int i = 0; i < 10; i++) begin
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: record held while the consumer withholds accepted
    send_line("[#] (0)\n", 0);
    wait_start(seen);
    chk("bp_start", {63'd0, seen}, 64'd1);
    held_btn = buttons;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_tready", {63'd0, s_axis_tready}, 64'd0);
      chk("bp_fields", {54'd0, start, num_lights, target_lights},
          {54'd0, 1'b1, 3'd1, 6'h01});
      chk("bp_buttons", {28'd0, buttons}, {28'd0, held_btn});
    end
    chk("bp_buttons_val", {28'd0, buttons}, {28'd0, mkb(6'h01, 0, 0, 0, 0, 0)});
    @(negedge clk);
    accepted = 1'b1;
    @(posedge clk);
    #1;
    accepted = 1'b0;
    exp_lines++;
    chk("bp_tready_after", {63'd0, s_axis_tready}, 64'd1);
    chk("bp_start_after", {63'd0, start}, 64'd0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("bp_lines", {48'd0, lines_out}, exp_lines);

    // Reset in the middle of a button group discards the partial line
    send_line("[##] (0,", 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_lines = 0;
    @(negedge clk);
    chk("rst_mid_start", {63'd0, start}, 64'd0);
    chk("rst_mid_lines", {48'd0, lines_out}, 64'd0);
    chk("rst_mid_err", {63'd0, parse_err}, 64'd0);
    chk("rst_mid_nl", {61'd0, num_lights}, 64'd0);
    check_vec("fresh", '{"[.#.] (1,2)\n", 0, 1, 0,
                         3'd3, 6'h02, 3'd1, mkb(6'h06, 0, 0, 0, 0, 0)});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
